// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction ROM and loads the IF/ID register.
// Optional end-of-memory halt is enabled with FETCH_BOUNDS_CHECK_EN; otherwise the PC wraps within MEM_SIZE.
module fetch_stage #(
   parameter int unsigned MEM_SIZE  = 1024,
   parameter logic [63:0] RESET_PC  = 64'd0,
   parameter logic [31:0] NOP_INSTR = 32'hD503201F
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [63:0] redirect_pc,
   output logic [63:0] imem_address,
   input  logic [31:0] imem_instruction,
   output logic [31:0] ifid_instr,
   output logic [63:0] ifid_pc,
   output logic        ifid_valid,
   output logic        halted,
   output logic [31:0] fetch_count
);

   typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

   state_t      r_state,  w_state_nxt;
   logic [63:0] r_pc,     w_pc_nxt;
   logic [31:0] r_instr,  w_instr_nxt;
   logic [63:0] r_ifpc,   w_ifpc_nxt;
   logic        r_valid,  w_valid_nxt;
   logic        r_halted, w_halted_nxt;
   logic [31:0] r_count,  w_count_nxt;
   logic [63:0] w_adv_pc, w_rd_pc;
   logic        w_at_end;

`ifdef FETCH_BOUNDS_CHECK_EN
   localparam logic [63:0] MEM_LIMIT = 64'(MEM_SIZE);

   assign w_adv_pc = r_pc + 64'd4;
   assign w_rd_pc  = redirect_pc & ~64'd3;
   assign w_at_end = (r_pc + 64'd3) >= MEM_LIMIT;
`else
   localparam logic [63:0] ADDR_MASK = 64'(MEM_SIZE - 1);

   // PC stays inside the ROM window and wraps to 0 past the end
   assign w_adv_pc = (r_pc + 64'd4) & ADDR_MASK;
   assign w_rd_pc  = redirect_pc & ~64'd3 & ADDR_MASK;
   assign w_at_end = 1'b0;
`endif

   // Next-state and register-update logic
   always_comb begin
      w_state_nxt  = r_state;
      w_pc_nxt     = r_pc;
      w_instr_nxt  = r_instr;
      w_ifpc_nxt   = r_ifpc;
      w_valid_nxt  = r_valid;
      w_halted_nxt = r_halted;
      w_count_nxt  = r_count;
      case (r_state)
         S_BOOT: w_state_nxt = S_RUN;
         S_RUN: begin
            if (redirect) begin
               w_pc_nxt    = w_rd_pc;
               w_instr_nxt = NOP_INSTR;
               w_valid_nxt = 1'b0;
            end else if (!stall) begin
               if (w_at_end) begin
                  w_state_nxt  = S_HALT;
                  w_halted_nxt = 1'b1;
                  w_instr_nxt  = NOP_INSTR;
                  w_valid_nxt  = 1'b0;
               end else begin
                  w_pc_nxt    = w_adv_pc;
                  w_instr_nxt = imem_instruction;
                  w_ifpc_nxt  = r_pc;
                  w_valid_nxt = 1'b1;
                  w_count_nxt = r_count + 32'd1;
               end
            end
         end
         default: w_state_nxt = r_state;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_BOOT;
         r_pc     <= RESET_PC;
         r_instr  <= NOP_INSTR;
         r_ifpc   <= 64'd0;
         r_valid  <= 1'b0;
         r_halted <= 1'b0;
         r_count  <= 32'd0;
      end else begin
         r_state  <= w_state_nxt;
         r_pc     <= w_pc_nxt;
         r_instr  <= w_instr_nxt;
         r_ifpc   <= w_ifpc_nxt;
         r_valid  <= w_valid_nxt;
         r_halted <= w_halted_nxt;
         r_count  <= w_count_nxt;
      end
   end

   assign imem_address = r_pc;
   assign ifid_instr   = r_instr;
   assign ifid_pc      = r_ifpc;
   assign ifid_valid   = r_valid;
   assign halted       = r_halted;
   assign fetch_count  = r_count;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined 64-bit ARM core.
- Owns the program counter and drives the byte address into the combinational instruction ROM.
- Captures the returned 32-bit word, with its PC, into the IF/ID pipeline register.
- Handles hazard-unit stalls, branch redirects with flush, and end-of-program halt detection.

Parameters:
- MEM_SIZE, 1024, instruction ROM size in bytes; power of two, >4.
- RESET_PC, 64'd0, PC value loaded on reset; word-aligned.
- NOP_INSTR, 32'hD503201F, encoding inserted into IF/ID on flush or halt.

Ports:
- clk  input  1  core clock; all state on rising edge.
- reset  input  1  synchronous, active-high.
- stall  input  1  hold PC and IF/ID (load-use hazard).
- redirect  input  1  branch taken; load redirect_pc and flush IF/ID.
- redirect_pc  input  64  branch target byte address.
- imem_address  output  64  byte address to instruction ROM; always equal to the current PC register.
- imem_instruction  input  32  ROM read data; combinational from imem_address.
- ifid_instr  output  32  registered instruction.
- ifid_pc  output  64  registered PC of ifid_instr.
- ifid_valid  output  1  ifid_instr is a real fetched instruction.
- halted  output  1  fetch has stopped at the end of memory.
- fetch_count  output  32  number of instructions captured into IF/ID.

Behaviour:
- Reset is synchronous and active-high. Reset values:
  - pc = RESET_PC, state = BOOT
  - ifid_instr = NOP_INSTR, ifid_pc = 0, ifid_valid = 0
  - halted = 0, fetch_count = 0
- Reset asserted mid-operation overrides everything on that edge.
- States:
  - BOOT: one cycle after reset release. No capture, pc holds, stall and redirect ignored. Next state is RUN.
  - RUN: normal fetch.
  - HALT: terminal. pc holds, IF/ID holds NOP with valid=0, halted=1. Left only by reset.
- RUN edge priority: redirect > stall > advance.
  - redirect=1 (takes priority even with stall=1):
    - pc <= {redirect_pc[63:2], 2'b00}
    - ifid_instr <= NOP_INSTR, ifid_valid <= 0; ifid_pc holds.
    - No count.
  - stall=1, redirect=0: pc, ifid_* and fetch_count all hold.
  - Advance:
    - ifid_instr <= imem_instruction, ifid_pc <= pc, ifid_valid <= 1
    - pc <= pc + 4
    - fetch_count <= fetch_count + 1 (wraps modulo 2^32).
- Latency: a word addressed in cycle N appears on ifid_* after the edge ending cycle N. First capture is from RESET_PC at the end of the first RUN cycle.
- Width rules: PC arithmetic is unsigned 64-bit. redirect_pc low two bits are silently cleared.

Optional Feature:
- Macro: FETCH_BOUNDS_CHECK_EN.
- Defined:
  - In RUN, with redirect=0 and stall=0, if pc + 3 >= MEM_SIZE, the edge moves to HALT.
  - That edge sets halted <= 1, ifid_instr <= NOP_INSTR, ifid_valid <= 0.
  - No capture and no count on that edge.
  - A redirect on that same edge wins: pc is reloaded, no halt.
  - A redirect into an out-of-range address halts on the following advance edge.
- Undefined:
  - No HALT state; halted is tied to 0.
  - Next pc (both advance and redirect) is masked to the range [0, MEM_SIZE-1], so the PC wraps to 0 past the end.

Test Plan:
- Reset held 2 cycles, then release with ROM words 0xA0,0xA1,0xA2 at 0,4,8 -> BOOT cycle has imem_address=0, ifid_valid=0; then successive edges give (ifid_pc,ifid_instr) = (0,0xA0), (4,0xA1), (8,0xA2), and fetch_count=3.
- stall=1 for 2 cycles while pc=8 -> imem_address stays 8; ifid stays (4,0xA1); fetch_count unchanged; after release the next capture is (8,0xA2).
- stall=1 and redirect=1 with redirect_pc=0x43 -> next edge gives pc=0x40, ifid_valid=0, ifid_instr=0xD503201F; the following edge captures (0x40, mem[16]).
- reset pulsed for 1 cycle while pc=0x20 and fetch_count=8 -> all outputs at reset values; BOOT observed again; fetch restarts at 0.
- With the macro defined, redirect to 0x3FC -> capture (0x3FC, mem[255]); next advance edge gives halted=1, ifid_valid=0, pc held at 0x400; stall and redirect have no effect until reset.
- With the macro undefined, the same stimulus -> after the 0x3FC capture, imem_address=0 and halted stays 0.
